// File: rtl/decode_pipe_pkg.sv
// Shared encodings for the decode stage: opcodes, ALU operations and halt FSM states.
// Treat these as the core-wide encoding table; other stages must not keep private copies.
package decode_pipe_pkg;

  localparam int OPCODE_W = 4;

  typedef enum logic [OPCODE_W-1:0] {
    OP_ADD  = 4'h0,
    OP_ADDZ = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_NOR  = 4'h4,
    OP_SLL  = 4'h5,
    OP_SRL  = 4'h6,
    OP_SRA  = 4'h7,
    OP_LW   = 4'h8,
    OP_SW   = 4'h9,
    OP_LHB  = 4'hA,
    OP_LLB  = 4'hB,
    OP_B    = 4'hC,
    OP_JAL  = 4'hD,
    OP_JR   = 4'hE,
    OP_HLT  = 4'hF
  } opcode_e;

  // ALU_NOP is zero so that a bubble bundle is also a no-op to the ALU.
  typedef enum logic [3:0] {
    ALU_NOP = 4'h0,
    ALU_ADD = 4'h1,
    ALU_SUB = 4'h2,
    ALU_AND = 4'h3,
    ALU_NOR = 4'h4,
    ALU_SLL = 4'h5,
    ALU_SRL = 4'h6,
    ALU_SRA = 4'h7,
    ALU_LHB = 4'h8
  } alu_op_e;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_e;

endpackage

// File: rtl/decode_pipe_load_use_detect.sv
// Combinational load-use hazard compare between the load sitting in EX and the ID instruction.
module load_use_detect #(
  parameter int REG_AW = 4
) (
  input  logic              i_ex_valid,
  input  logic              i_ex_mem_rd,
  input  logic [REG_AW-1:0] i_ex_wr_reg,
  input  logic              i_id_rd_en1,
  input  logic              i_id_rd_en2,
  input  logic [REG_AW-1:0] i_id_rd_reg1,
  input  logic [REG_AW-1:0] i_id_rd_reg2,
  output logic              o_hazard
);

  logic w_load_in_ex;
  logic w_match1;
  logic w_match2;

  // Register 0 is hard-wired, so a load targeting it never creates a dependency.
  assign w_load_in_ex = i_ex_valid & i_ex_mem_rd & (i_ex_wr_reg != '0);
  assign w_match1     = i_id_rd_en1 & (i_id_rd_reg1 == i_ex_wr_reg);
  assign w_match2     = i_id_rd_en2 & (i_id_rd_reg2 == i_ex_wr_reg);
  assign o_hazard     = w_load_in_ex & (w_match1 | w_match2);

endmodule

// File: rtl/decode_pipe.sv
// Registered ID/EX decode stage with load-use bubbles, flush handling and a halt-drain FSM.
// Define DECODE_ADDZ_EN to decode ADDZ as a Z-conditional ADD; otherwise ADDZ is a valid NOP.
module decode_pipe
  import decode_pipe_pkg::*;
#(
  parameter int INSTR_W   = 16,
  parameter int REG_AW    = 4,
  parameter int DRAIN_CYC = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INSTR_W-1:0] instr,
  input  logic               id_valid,
  input  logic               flush,
  input  logic               z_in,
  output logic               id_stall,
  output logic               ex_valid,
  output logic               ex_rd_en1,
  output logic               ex_rd_en2,
  output logic               ex_wr_en,
  output logic               ex_mem_rd,
  output logic               ex_mem_wr,
  output logic               ex_mem2reg,
  output logic               ex_br,
  output logic               ex_j,
  output logic               ex_alu_src,
  output logic [REG_AW-1:0]  ex_rd_reg1,
  output logic [REG_AW-1:0]  ex_rd_reg2,
  output logic [REG_AW-1:0]  ex_wr_reg,
  output logic [3:0]         ex_alu_op,
  output logic [3:0]         ex_sh_amt,
  output logic               halting,
  output logic               hlt
);

  localparam int CNT_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam int FA_HI = INSTR_W - OPCODE_W - 1;
  localparam int FB_HI = FA_HI - REG_AW;
  localparam int FC_HI = FB_HI - REG_AW;

  typedef struct packed {
    logic              valid;
    logic              rd_en1;
    logic              rd_en2;
    logic              wr_en;
    logic              mem_rd;
    logic              mem_wr;
    logic              mem2reg;
    logic              br;
    logic              j;
    logic              alu_src;
    logic [REG_AW-1:0] rd_reg1;
    logic [REG_AW-1:0] rd_reg2;
    logic [REG_AW-1:0] wr_reg;
    logic [3:0]        alu_op;
    logic [3:0]        sh_amt;
  } bundle_t;

  opcode_e           w_op;
  logic [REG_AW-1:0] w_fa;
  logic [REG_AW-1:0] w_fb;
  logic [REG_AW-1:0] w_fc;
  bundle_t           w_dec;
  bundle_t           r_ex;
  logic              w_hazard;
  logic              w_accept;
  state_e            r_state;
  state_e            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;

  assign w_op = opcode_e'(instr[INSTR_W-1 -: OPCODE_W]);
  assign w_fa = instr[FA_HI -: REG_AW];
  assign w_fb = instr[FB_HI -: REG_AW];
  assign w_fc = instr[FC_HI -: REG_AW];

  always_comb begin
    w_dec         = '0;
    w_dec.valid   = 1'b1;
    w_dec.rd_en1  = !(w_op inside {OP_HLT, OP_B, OP_JAL});
    w_dec.rd_en2  = w_op inside {OP_ADD, OP_ADDZ, OP_SUB, OP_AND, OP_NOR, OP_SW};
    w_dec.wr_en   = !(w_op inside {OP_HLT, OP_SW, OP_B, OP_JR});
    w_dec.mem_rd  = (w_op == OP_LW);
    w_dec.mem_wr  = (w_op == OP_SW);
    w_dec.mem2reg = (w_op == OP_LW);
    w_dec.br      = (w_op == OP_B);
    w_dec.j       = w_op inside {OP_JAL, OP_JR};
    w_dec.rd_reg1 = (w_op == OP_LHB) ? w_fa : (w_op == OP_LLB) ? '0 : w_fb;
    w_dec.rd_reg2 = (w_op == OP_SW) ? w_fa : (w_op == OP_JR) ? '0 : w_fc;
    w_dec.wr_reg  = (w_op == OP_JAL) ? '1 :
                    (w_op inside {OP_SW, OP_B, OP_JR, OP_HLT}) ? '0 : w_fa;
    w_dec.alu_src = (w_op inside {OP_LLB, OP_SW}) ? 1'b0 :
                    (w_op == OP_JR) ? 1'b1 : w_dec.rd_en2;
    w_dec.sh_amt  = instr[3:0];
    case (w_op)
      OP_ADD, OP_ADDZ, OP_LLB, OP_LW, OP_SW, OP_JR: w_dec.alu_op = ALU_ADD;
      OP_SUB:  w_dec.alu_op = ALU_SUB;
      OP_AND:  w_dec.alu_op = ALU_AND;
      OP_NOR:  w_dec.alu_op = ALU_NOR;
      OP_SLL:  w_dec.alu_op = ALU_SLL;
      OP_SRL:  w_dec.alu_op = ALU_SRL;
      OP_SRA:  w_dec.alu_op = ALU_SRA;
      OP_LHB:  w_dec.alu_op = ALU_LHB;
      default: w_dec.alu_op = ALU_NOP;
    endcase
    // HLT never reaches EX; its only effect is starting the drain.
    if (w_op == OP_HLT) begin
      w_dec = '0;
    end else if (w_op == OP_ADDZ) begin
`ifdef DECODE_ADDZ_EN
      w_dec.wr_en = z_in;
`else
      w_dec       = '0;
      w_dec.valid = 1'b1;
`endif
    end
  end

`ifndef DECODE_ADDZ_EN
  logic w_unused_z;
  assign w_unused_z = z_in;
`endif

  load_use_detect #(
    .REG_AW(REG_AW)
  ) u_load_use_detect (
    .i_ex_valid  (r_ex.valid),
    .i_ex_mem_rd (r_ex.mem_rd),
    .i_ex_wr_reg (r_ex.wr_reg),
    .i_id_rd_en1 (w_dec.rd_en1),
    .i_id_rd_en2 (w_dec.rd_en2),
    .i_id_rd_reg1(w_dec.rd_reg1),
    .i_id_rd_reg2(w_dec.rd_reg2),
    .o_hazard    (w_hazard)
  );

  assign id_stall = w_hazard | (r_state != RUN);
  assign w_accept = id_valid & ~flush & ~id_stall;

  // Flush, stall and an empty ID slot all collapse to loading a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex <= '0;
    end else begin
      r_ex <= w_accept ? w_dec : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      RUN: begin
        if (w_accept && (w_op == OP_HLT)) begin
          w_state_nxt = DRAIN;
          w_cnt_nxt   = CNT_W'(DRAIN_CYC - 1);
        end
      end
      DRAIN: begin
        // A flush here means the HLT was fetched down a mispredicted path.
        if (flush) begin
          w_state_nxt = RUN;
          w_cnt_nxt   = '0;
        end else if (r_cnt == '0) begin
          w_state_nxt = HALTED;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      HALTED:  w_state_nxt = HALTED;
      default: w_state_nxt = RUN;
    endcase
  end

  assign halting    = (r_state == DRAIN);
  assign hlt        = (r_state == HALTED);
  assign ex_valid   = r_ex.valid;
  assign ex_rd_en1  = r_ex.rd_en1;
  assign ex_rd_en2  = r_ex.rd_en2;
  assign ex_wr_en   = r_ex.wr_en;
  assign ex_mem_rd  = r_ex.mem_rd;
  assign ex_mem_wr  = r_ex.mem_wr;
  assign ex_mem2reg = r_ex.mem2reg;
  assign ex_br      = r_ex.br;
  assign ex_j       = r_ex.j;
  assign ex_alu_src = r_ex.alu_src;
  assign ex_rd_reg1 = r_ex.rd_reg1;
  assign ex_rd_reg2 = r_ex.rd_reg2;
  assign ex_wr_reg  = r_ex.wr_reg;
  assign ex_alu_op  = r_ex.alu_op;
  assign ex_sh_amt  = r_ex.sh_amt;

endmodule

// File: tb/tb_decode_pipe.sv
// Self-checking bench for decode_pipe: a per-cycle reference model plus directed scenarios.
// Honours DECODE_ADDZ_EN the same way as the design when building ADDZ expectations.
module tb_decode_pipe;
  import decode_pipe_pkg::*;

  localparam int DRAIN_CYC = 3;

  typedef struct packed {
    logic       valid, rdEn1, rdEn2, wrEn, memRd, memWr, mem2reg, br, j, aluSrc;
    logic [3:0] rdReg1, rdReg2, wrReg, aluOp, shAmt;
  } bundle_t;

  logic clk, rst_n;
  logic [15:0] instr;
  logic id_valid, flush, z_in;
  logic id_stall, ex_valid, ex_rd_en1, ex_rd_en2, ex_wr_en, ex_mem_rd, ex_mem_wr;
  logic ex_mem2reg, ex_br, ex_j, ex_alu_src, halting, hlt;
  logic [3:0] ex_rd_reg1, ex_rd_reg2, ex_wr_reg, ex_alu_op, ex_sh_amt;

  logic [19:0] instr20;
  logic id_valid20;
  logic ex_valid20, ex_rd_en1_20, ex_j20;
  logic [4:0] ex_rd_reg1_20, ex_rd_reg2_20, ex_wr_reg20;
  logic unused20Stall, unused20RdEn2, unused20WrEn, unused20MemRd, unused20MemWr;
  logic unused20Mem2reg, unused20Br, unused20AluSrc, unused20Halting, unused20Hlt;
  logic [3:0] unused20AluOp, unused20ShAmt;

  bundle_t obs, mEx;
  int mMode, mLeft;
  logic expStall, obsStall;
  int testsRun, testsFailed;

  decode_pipe #(.INSTR_W(16), .REG_AW(4), .DRAIN_CYC(DRAIN_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .id_valid(id_valid), .flush(flush), .z_in(z_in),
    .id_stall(id_stall), .ex_valid(ex_valid), .ex_rd_en1(ex_rd_en1), .ex_rd_en2(ex_rd_en2),
    .ex_wr_en(ex_wr_en), .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr), .ex_mem2reg(ex_mem2reg),
    .ex_br(ex_br), .ex_j(ex_j), .ex_alu_src(ex_alu_src), .ex_rd_reg1(ex_rd_reg1),
    .ex_rd_reg2(ex_rd_reg2), .ex_wr_reg(ex_wr_reg), .ex_alu_op(ex_alu_op), .ex_sh_amt(ex_sh_amt),
    .halting(halting), .hlt(hlt)
  );

  decode_pipe #(.INSTR_W(20), .REG_AW(5), .DRAIN_CYC(DRAIN_CYC)) dut20 (
    .clk(clk), .rst_n(rst_n), .instr(instr20), .id_valid(id_valid20), .flush(1'b0), .z_in(1'b0),
    .id_stall(unused20Stall), .ex_valid(ex_valid20), .ex_rd_en1(ex_rd_en1_20),
    .ex_rd_en2(unused20RdEn2), .ex_wr_en(unused20WrEn), .ex_mem_rd(unused20MemRd),
    .ex_mem_wr(unused20MemWr), .ex_mem2reg(unused20Mem2reg), .ex_br(unused20Br), .ex_j(ex_j20),
    .ex_alu_src(unused20AluSrc), .ex_rd_reg1(ex_rd_reg1_20), .ex_rd_reg2(ex_rd_reg2_20),
    .ex_wr_reg(ex_wr_reg20), .ex_alu_op(unused20AluOp), .ex_sh_amt(unused20ShAmt),
    .halting(unused20Halting), .hlt(unused20Hlt)
  );

  assign obs = {ex_valid, ex_rd_en1, ex_rd_en2, ex_wr_en, ex_mem_rd, ex_mem_wr, ex_mem2reg,
                ex_br, ex_j, ex_alu_src, ex_rd_reg1, ex_rd_reg2, ex_wr_reg, ex_alu_op, ex_sh_amt};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // What the stage should hand to EX for one instruction, straight from the opcode rules.
  function automatic bundle_t refDecode(input logic [15:0] ins, input logic z);
    bundle_t b;
    opcode_e op;
    logic [3:0] fa, fb, fc;
    b  = '0;
    op = opcode_e'(ins[15:12]);
    fa = ins[11:8];
    fb = ins[7:4];
    fc = ins[3:0];
    if (op == OP_HLT) return b;
    b.valid = 1'b1;
`ifndef DECODE_ADDZ_EN
    if (op == OP_ADDZ) return b;
`endif
    b.rdEn1   = !(op inside {OP_HLT, OP_B, OP_JAL});
    b.rdEn2   = op inside {OP_ADD, OP_ADDZ, OP_SUB, OP_AND, OP_NOR, OP_SW};
    b.wrEn    = (op == OP_ADDZ) ? z : !(op inside {OP_SW, OP_B, OP_JR});
    b.memRd   = (op == OP_LW);
    b.memWr   = (op == OP_SW);
    b.mem2reg = b.memRd;
    b.br      = (op == OP_B);
    b.j       = (op == OP_JAL) || (op == OP_JR);
    b.rdReg1  = (op == OP_LHB) ? fa : (op == OP_LLB) ? 4'd0 : fb;
    b.rdReg2  = (op == OP_SW) ? fa : (op == OP_JR) ? 4'd0 : fc;
    b.wrReg   = (op == OP_JAL) ? 4'hF : (op inside {OP_SW, OP_B, OP_JR}) ? 4'd0 : fa;
    b.aluSrc  = (op inside {OP_LLB, OP_SW}) ? 1'b0 : (op == OP_JR) ? 1'b1 : b.rdEn2;
    b.shAmt   = ins[3:0];
    if (op inside {OP_ADD, OP_ADDZ, OP_LLB, OP_LW, OP_SW, OP_JR}) b.aluOp = ALU_ADD;
    else if (op == OP_SUB) b.aluOp = ALU_SUB;
    else if (op == OP_AND) b.aluOp = ALU_AND;
    else if (op == OP_NOR) b.aluOp = ALU_NOR;
    else if (op == OP_SLL) b.aluOp = ALU_SLL;
    else if (op == OP_SRL) b.aluOp = ALU_SRL;
    else if (op == OP_SRA) b.aluOp = ALU_SRA;
    else if (op == OP_LHB) b.aluOp = ALU_LHB;
    else b.aluOp = ALU_NOP;
    return b;
  endfunction

  function automatic logic refHazard(input bundle_t ex, input bundle_t d);
    if (!(ex.valid && ex.memRd && ex.wrReg != 4'd0)) return 1'b0;
    return (d.rdEn1 && d.rdReg1 == ex.wrReg) || (d.rdEn2 && d.rdReg2 == ex.wrReg);
  endfunction

  task automatic doReset();
    rst_n = 1'b0;
    instr = '0; id_valid = 1'b0; flush = 1'b0; z_in = 1'b0;
    instr20 = '0; id_valid20 = 1'b0;
    mEx = '0; mMode = 0; mLeft = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drives one ID cycle, samples id_stall before the edge, advances the model by one edge.
  task automatic applyStimulus(input logic [15:0] ins, input logic v, input logic f, input logic z);
    bundle_t d, nxt;
    instr = ins; id_valid = v; flush = f; z_in = z;
    #1;
    d        = refDecode(ins, z);
    expStall = refHazard(mEx, d) || (mMode != 0);
    obsStall = id_stall;
    nxt      = (f || expStall || !v) ? '0 : d;
    if (mMode == 0) begin
      if (v && !f && !expStall && ins[15:12] == 4'hF) begin
        mMode = 1;
        mLeft = DRAIN_CYC;
      end
    end else if (mMode == 1) begin
      if (f) mMode = 0;
      else begin
        mLeft--;
        if (mLeft == 0) mMode = 2;
      end
    end
    @(posedge clk);
    mEx = nxt;
    @(negedge clk);
  endtask

  function automatic logic [15:0] randNonHlt();
    logic [3:0] op;
    op = 4'($urandom_range(0, 14));
    return {op, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    instr = '0; id_valid = 1'b0; flush = 1'b0; z_in = 1'b0;
    instr20 = '0; id_valid20 = 1'b0;
    @(negedge clk);
    testsRun++;
    if (obs !== '0) begin testsFailed++; $display("[TB] FAIL reset_bundle: got %h want 0", obs); end
    testsRun++;
    if ({id_stall, halting, hlt} !== 3'b000) begin
      testsFailed++; $display("[TB] FAIL reset_status: stall/halting/hlt got %b want 000", {id_stall, halting, hlt});
    end
    doReset();
  endtask

  task automatic test_add();
    applyStimulus(16'h0312, 1'b1, 1'b0, 1'b0);
    testsRun++;
    if (obs !== mEx) begin testsFailed++; $display("[TB] FAIL add_bundle: got %h want %h", obs, mEx); end
    testsRun++;
    if ({ex_valid, ex_wr_reg, ex_rd_reg1, ex_rd_reg2, ex_alu_op} !== {1'b1, 4'd3, 4'd1, 4'd2, ALU_ADD}) begin
      testsFailed++;
      $display("[TB] FAIL add_fields: valid/wr/rd1/rd2/op got %b/%0d/%0d/%0d/%0d want 1/3/1/2/%0d",
               ex_valid, ex_wr_reg, ex_rd_reg1, ex_rd_reg2, ex_alu_op, ALU_ADD);
    end
  endtask

  task automatic test_load_use();
    applyStimulus(16'h8410, 1'b1, 1'b0, 1'b0);
    applyStimulus(16'h0541, 1'b1, 1'b0, 1'b0);
    testsRun++;
    if (obsStall !== 1'b1 || ex_valid !== 1'b0) begin
      testsFailed++; $display("[TB] FAIL load_use_stall: stall %b valid %b want 1 0", obsStall, ex_valid);
    end
    applyStimulus(16'h0541, 1'b1, 1'b0, 1'b0);
    testsRun++;
    if (obsStall !== 1'b0 || ex_valid !== 1'b1 || ex_rd_reg1 !== 4'd4 || obs !== mEx) begin
      testsFailed++; $display("[TB] FAIL load_use_accept: stall %b bundle %h want 0 %h", obsStall, obs, mEx);
    end
    applyStimulus(16'h8010, 1'b1, 1'b0, 1'b0);
    applyStimulus(16'h0501, 1'b1, 1'b0, 1'b0);
    testsRun++;
    if (obsStall !== 1'b0 || ex_valid !== 1'b1) begin
      testsFailed++; $display("[TB] FAIL load_r0_no_stall: stall %b valid %b want 0 1", obsStall, ex_valid);
    end
  endtask

  task automatic test_flush_hazard();
    applyStimulus(16'h8410, 1'b1, 1'b0, 1'b0);
    applyStimulus(16'h0541, 1'b1, 1'b1, 1'b0);
    testsRun++;
    if (obsStall !== 1'b1 || obs !== '0) begin
      testsFailed++; $display("[TB] FAIL flush_hazard_cycle: stall %b bundle %h want 1 0", obsStall, obs);
    end
    applyStimulus(16'h2672, 1'b1, 1'b0, 1'b0);
    testsRun++;
    if (obsStall !== 1'b0 || ex_valid !== 1'b1 || obs !== mEx) begin
      testsFailed++; $display("[TB] FAIL flush_next_accept: stall %b bundle %h want 0 %h", obsStall, obs, mEx);
    end
  endtask

  task automatic test_halt();
    int haltCount, firstHlt;
    doReset();
    applyStimulus(16'hF000, 1'b1, 1'b0, 1'b0);
    haltCount = halting ? 1 : 0;
    firstHlt  = 0;
    testsRun++;
    if (halting !== 1'b1 || ex_valid !== 1'b0) begin
      testsFailed++; $display("[TB] FAIL halt_enter: halting %b valid %b want 1 0", halting, ex_valid);
    end
    for (int i = 0; i < 8; i++) begin
      applyStimulus(randNonHlt(), 1'b1, 1'b0, 1'($urandom_range(0, 1)));
      if (halting) haltCount++;
      if (hlt && firstHlt == 0) firstHlt = i + 2;
      testsRun++;
      if (obsStall !== 1'b1 || hlt !== (mMode == 2) || halting !== (mMode == 1) || obs !== mEx) begin
        testsFailed++;
        $display("[TB] FAIL halt_drain_cycle%0d: stall %b halting %b hlt %b bundle %h want 1 %b %b %h",
                 i, obsStall, halting, hlt, obs, mMode == 1, mMode == 2, mEx);
      end
    end
    testsRun++;
    if (haltCount != DRAIN_CYC || firstHlt != DRAIN_CYC + 1 || hlt !== 1'b1 || id_stall !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL halt_timing: halting cycles %0d hlt edge %0d hlt %b stall %b want %0d %0d 1 1",
               haltCount, firstHlt, hlt, id_stall, DRAIN_CYC, DRAIN_CYC + 1);
    end
  endtask

  task automatic test_drain_flush();
    doReset();
    applyStimulus(16'hF000, 1'b1, 1'b0, 1'b0);
    applyStimulus(16'h0312, 1'b1, 1'b1, 1'b0);
    testsRun++;
    if (halting !== 1'b0 || hlt !== 1'b0 || obs !== '0) begin
      testsFailed++; $display("[TB] FAIL drain_flush_exit: halting %b hlt %b bundle %h want 0 0 0", halting, hlt, obs);
    end
    for (int i = 0; i < 6; i++) begin
      applyStimulus(randNonHlt(), 1'b1, 1'b0, 1'($urandom_range(0, 1)));
      testsRun++;
      if (hlt !== 1'b0 || halting !== 1'b0 || obs !== mEx || obsStall !== expStall) begin
        testsFailed++;
        $display("[TB] FAIL drain_flush_run%0d: hlt %b halting %b stall %b bundle %h want 0 0 %b %h",
                 i, hlt, halting, obsStall, obs, expStall, mEx);
      end
    end
  endtask

  task automatic test_reset_mid_drain();
    doReset();
    applyStimulus(16'hF000, 1'b1, 1'b0, 1'b0);
    applyStimulus(16'h0312, 1'b1, 1'b0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    testsRun++;
    if (halting !== 1'b0 || hlt !== 1'b0 || id_stall !== 1'b0 || obs !== '0) begin
      testsFailed++;
      $display("[TB] FAIL async_reset_drain: halting %b hlt %b stall %b bundle %h want 0 0 0 0", halting, hlt, id_stall, obs);
    end
    doReset();
  endtask

  task automatic test_addz();
    logic firstWr, secondWr;
`ifdef DECODE_ADDZ_EN
    firstWr = 1'b0; secondWr = 1'b1;
`else
    firstWr = 1'b0; secondWr = 1'b0;
`endif
    applyStimulus(16'h1312, 1'b1, 1'b0, 1'b0);
    testsRun++;
    if (ex_wr_en !== firstWr || ex_valid !== 1'b1 || obs !== mEx) begin
      testsFailed++; $display("[TB] FAIL addz_z0: wr_en %b bundle %h want %b %h", ex_wr_en, obs, firstWr, mEx);
    end
    applyStimulus(16'h1312, 1'b1, 1'b0, 1'b1);
    testsRun++;
    if (ex_wr_en !== secondWr || ex_valid !== 1'b1 || obs !== mEx) begin
      testsFailed++; $display("[TB] FAIL addz_z1: wr_en %b bundle %h want %b %h", ex_wr_en, obs, secondWr, mEx);
    end
  endtask

  task automatic test_random();
    logic [15:0] ins;
    for (int i = 0; i < 300; i++) begin
      ins = randNonHlt();
      applyStimulus(ins, $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, 1'($urandom_range(0, 1)));
      testsRun++;
      if (obsStall !== expStall || obs !== mEx || halting !== 1'b0 || hlt !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL random%0d instr %h: stall %b bundle %h want %b %h", i, ins, obsStall, obs, expStall, mEx);
      end
    end
  endtask

  task automatic test_jal_wide();
    instr20 = {4'hD, 16'($urandom)}; id_valid20 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    testsRun++;
    if (ex_wr_reg20 !== 5'h1F || ex_j20 !== 1'b1 || ex_rd_en1_20 !== 1'b0 || ex_valid20 !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL jal_wide: wr %h j %b rd_en1 %b valid %b want 1f 1 0 1", ex_wr_reg20, ex_j20, ex_rd_en1_20, ex_valid20);
    end
    instr20 = {4'h0, 5'd17, 5'd9, 5'd30, 1'b0};
    @(posedge clk);
    @(negedge clk);
    testsRun++;
    if (ex_wr_reg20 !== 5'd17 || ex_rd_reg1_20 !== 5'd9 || ex_rd_reg2_20 !== 5'd30) begin
      testsFailed++;
      $display("[TB] FAIL add_wide_fields: wr/rd1/rd2 %0d/%0d/%0d want 17/9/30", ex_wr_reg20, ex_rd_reg1_20, ex_rd_reg2_20);
    end
    id_valid20 = 1'b0;
  endtask

  initial begin
    testsRun = 0;
    testsFailed = 0;
    test_reset();
    test_add();
    test_load_use();
    test_flush_hazard();
    test_addz();
    test_random();
    test_jal_wide();
    test_halt();
    test_drain_flush();
    test_reset_mid_drain();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
